// File: rtl/dff_pipe_pkg.sv
// Shared defaults and sizing helper for the dff_pipe register pipeline.
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH = 8;
    localparam int DFF_PIPE_DEPTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid bit plus a data word, loaded from upstream and
// emptied when its word moves downstream.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DFF_PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             advance,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // A load wins over an advance so a moving stage refills in the same cycle;
    // data is left untouched when the slot empties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (advance) begin
                valid <= 1'b0;
            end
            if (load && !flush) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline of DEPTH valid/data stages with bubble collapse,
// backpressure, synchronous flush and an occupancy count.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DFF_PIPE_WIDTH,
    parameter int               DEPTH   = DFF_PIPE_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH:0]   down_free;

    // Ready ripples from the output back to the input: a stage may move when
    // the slot below it is empty or is itself moving this cycle.
    always_comb begin
        down_free        = '0;
        adv              = '0;
        down_free[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i]       = valid[i] & down_free[i + 1];
            down_free[i] = ~valid[i] | adv[i];
        end
    end

    assign in_ready = down_free[0] & ~flush;

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i - 1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] src;
        if (i == 0) begin : g_head
            assign src = in_data;
        end else begin : g_body
            assign src = stage_data[i - 1];
        end

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (load[i]),
            .load_data (src),
            .advance   (adv[i]),
            .valid     (valid[i]),
            .data      (stage_data[i])
        );
    end

    assign out_valid = valid[DEPTH - 1];
    assign out_data  = stage_data[DEPTH - 1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=8'hA5) with an
// in-order scoreboard of accepted words.
module tb_dff_pipe;

    localparam int             WIDTH   = 8;
    localparam int             DEPTH   = 4;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;
    localparam int             OCC_W   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             flush = 1'b0;
    logic [OCC_W-1:0] occupancy;

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int accepted    = 0;
    int consumed    = 0;
    int max_occ     = 0;
    bit check_latency = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    int               acc_cyc_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, note the handshakes seen just before the edge
    // and score any consumed word against the queue of accepted words.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id,
                                 input logic ordy, input logic fl);
        logic acc, cons;
        logic [WIDTH-1:0] od;
        int a;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #2;
        acc  = rst && in_valid && in_ready;
        cons = rst && out_valid && out_ready;
        od   = out_data;
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        @(posedge clk);
        cyc++;
        #1;
        if (cons) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_output", 32'(cons), 32'd0);
            end else begin
                checkOutput("out_data_order", 32'(od), 32'(exp_q.pop_front()));
                a = acc_cyc_q.pop_front();
                if (check_latency) checkOutput("latency", 32'(cyc - a), 32'd4);
                consumed++;
            end
        end
        if (fl) begin
            checkOutput("in_ready_during_flush", 32'(acc), 32'd0);
            exp_q.delete();
            acc_cyc_q.delete();
        end else if (acc) begin
            exp_q.push_back(id);
            acc_cyc_q.push_back(cyc);
            accepted++;
        end
    endtask

    initial begin
        int a0, c0, idx;

        // Reset held for three cycles
        #1 rst = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'(RST_VAL));
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back streaming of 01..08
        check_latency = 1'b1;
        max_occ = 0;
        a0 = accepted;
        c0 = consumed;
        for (int k = 0; k < 40 && (consumed - c0) < 8; k++) begin
            idx = accepted - a0;
            if (idx < 8) applyStimulus(1'b1, WIDTH'(idx + 1), 1'b1, 1'b0);
            else         applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        check_latency = 1'b0;
        checkOutput("stream_count", 32'(consumed - c0), 32'd8);
        checkOutput("stream_peak_occ", 32'(max_occ), 32'd4);

        // Backpressure: six words offered with out_ready low
        a0 = accepted;
        c0 = consumed;
        for (int k = 0; k < 7; k++) begin
            idx = accepted - a0;
            applyStimulus(1'b1, WIDTH'(idx + 1), 1'b0, 1'b0);
        end
        checkOutput("bp_accepts", 32'(accepted - a0), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
        for (int k = 0; k < 40 && (consumed - c0) < 6; k++) begin
            idx = accepted - a0;
            if (idx < 6) applyStimulus(1'b1, WIDTH'(idx + 1), 1'b1, 1'b0);
            else         applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("bp_drained", 32'(consumed - c0), 32'd6);

        // Bubble collapse with the output stalled
        c0 = consumed;
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("bubble_valid_bits", 32'(dut.valid), 32'h0000_000C);
        checkOutput("bubble_occupancy", 32'(occupancy), 32'd2);
        checkOutput("bubble_out_data", 32'(out_data), 32'h11);
        for (int k = 0; k < 12 && (consumed - c0) < 2; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("bubble_drained", 32'(consumed - c0), 32'd2);

        // Flush with three words inside and FF offered
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("pre_flush_occupancy", 32'(occupancy), 32'd3);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        checkOutput("flush_occupancy", 32'(occupancy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Reset while four words are in flight
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, WIDTH'(8'h51 + k), 1'b0, 1'b0);
        end
        checkOutput("midrst_pre_occupancy", 32'(occupancy), 32'd4);
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'(RST_VAL));
        checkOutput("midrst_occupancy", 32'(occupancy), 32'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        repeat (2) applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        rst = 1'b1;
        a0 = accepted;
        c0 = consumed;
        for (int k = 0; k < 20 && (consumed - c0) < 1; k++) begin
            if (accepted == a0) applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
            else                applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("midrst_post_count", 32'(consumed - c0), 32'd1);
        checkOutput("midrst_final_occupancy", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages; legal range 1..16.
REQ-003 Parameter RST_VAL, default 0 (WIDTH bits): value loaded into every stage data register on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream data word.
REQ-008 in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 out_valid  output  1  last stage holds a valid word.
REQ-010 out_data  output  WIDTH  last-stage data word.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 flush  input  1  synchronous clear of all valid bits.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Pipe SHALL hold DEPTH stages, each a WIDTH-bit data register plus a valid bit; stage 0 is input side, stage DEPTH-1 drives out_data/out_valid.
REQ-015 Input handshake SHALL complete on a rising edge with in_valid=1 and in_ready=1; output handshake SHALL complete with out_valid=1 and out_ready=1.
REQ-016 Stage i SHALL advance when valid and (i=DEPTH-1 ? out_ready : stage i+1 empty or advancing); bubbles SHALL collapse.
REQ-017 in_ready SHALL equal (stage 0 empty or stage 0 advancing) and flush=0; combinational ready chain across DEPTH stages is accepted.
REQ-018 With out_ready held 1 and pipe empty, a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+DEPTH-1 (latency DEPTH cycles from acceptance to consumption).
REQ-019 Full pipe with out_ready=1 SHALL sustain one word per cycle, simultaneous accept and consume.
REQ-020 out_ready=0 SHALL stall last stage; stalled and non-advancing stages SHALL hold data and valid unchanged; upstream stages SHALL fill bubbles.
REQ-021 Empty stages SHALL hold previous data (no clear); only valid bit cleared.
REQ-022 Ordering SHALL be strict FIFO; no word dropped or duplicated outside flush.
REQ-023 flush=1 at an edge SHALL clear all valid bits; in_valid that cycle is not accepted (in_ready=0); an output handshake in the flush cycle SHALL count as consumed.
REQ-024 occupancy SHALL equal number of set valid bits, registered-consistent with stage state (combinational popcount or counter, +1 accept, -1 consume, both = unchanged, flush -> 0).
REQ-025 DEPTH=1 SHALL behave as a single-entry register slice with in_ready = !valid or out_ready.

Reset
REQ-026 rst=0 SHALL asynchronously force all valid bits 0, all data registers to RST_VAL, occupancy 0.
REQ-027 During and after reset: out_valid=0, out_data=RST_VAL, in_ready=1 from first cycle after rst release (flush=0).
REQ-028 Reset mid-transfer SHALL discard all in-flight words; no handshake completes while rst=0.

Structure
REQ-029 Package dff_pipe_pkg SHALL hold default constants DFF_PIPE_WIDTH=8, DFF_PIPE_DEPTH=4 and function for occupancy width.
REQ-030 One sub-module dff_pipe_stage (one valid+data register with advance/load logic) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=4, RST_VAL=8'hA5)
REQ-031 Reset: hold rst=0 3 cycles -> out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1 after release.
REQ-032 Streaming: push 8'h01..8'h08 back-to-back, out_ready=1 -> 8'h01 consumed 4 cycles after acceptance, then one word/cycle in order, occupancy peaks at 4.
REQ-033 Backpressure: push 6 words with out_ready=0 -> in_ready drops after 4 accepts, occupancy=4; raise out_ready -> words 1..6 emerge in order, none lost.
REQ-034 Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22, out_ready=0 -> both stages settle at DEPTH-1, DEPTH-2; occupancy=2.
REQ-035 Flush: fill 3 words, assert flush 1 cycle with in_valid=1 8'hFF -> next cycle occupancy=0, out_valid=0, 8'hFF never emerges.
REQ-036 Reset mid-stream: drop rst while 4 words in flight -> immediate out_valid=0, out_data=8'hA5; post-release push 8'h33 emerges alone.
